// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: ROM, decoder, ALU-flag and data-memory handshake bundle around the sequencer
interface cpu_sequencer_if #(
   parameter int PC_W  = 8,
   parameter int LIT_W = 8
);
   logic [6+LIT_W:0] instr_in;
   logic [PC_W-1:0]  pc;
   logic [6:0]       opcode;
   logic [LIT_W-1:0] literal;
   logic             dec_mem_read;
   logic             dec_mem_write;
   logic             dec_pc_load;
   logic             dec_flag_we;
   logic             alu_z;
   logic             alu_n;
   logic             alu_c;
   logic             alu_v;
   logic             flag_z;
   logic             flag_n;
   logic             flag_c;
   logic             flag_v;
   logic             mem_req;
   logic             mem_ack;
   logic             commit;
   modport master (
      input  instr_in, dec_mem_read, dec_mem_write, dec_pc_load, dec_flag_we,
             alu_z, alu_n, alu_c, alu_v, mem_ack,
      output pc, opcode, literal, flag_z, flag_n, flag_c, flag_v, mem_req, commit
   );
   modport slave (
      output instr_in, dec_mem_read, dec_mem_write, dec_pc_load, dec_flag_we,
             alu_z, alu_n, alu_c, alu_v, mem_ack,
      input  pc, opcode, literal, flag_z, flag_n, flag_c, flag_v, mem_req, commit
   );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/execute sequencer owning PC, IR and flags; SEQ_RETIRE_CNT_EN adds a retired-instruction counter
module cpu_sequencer #(
   parameter int         PC_W     = 8,
   parameter int         LIT_W    = 8,
   parameter logic [6:0] HALT_OPC = 7'b1111111,
   parameter int         TIMEOUT  = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   cpu_sequencer_if.master      bus,
   output logic                 halted,
   output logic                 err_timeout,
   output logic [15:0]          instr_count
);
   typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;
   state_t           state, nxt;
   logic [PC_W-1:0]  pc;
   logic [6+LIT_W:0] ir;
   logic [3:0]       flags;
   logic [7:0]       cnt, cnt_nxt;
   logic             commit, to_err, mem_req;
   assign bus.pc      = pc;
   assign bus.opcode  = ir[6+LIT_W:LIT_W];
   assign bus.literal = ir[LIT_W-1:0];
   assign bus.commit  = commit;
   assign bus.mem_req = mem_req;
   assign {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} = flags;
   assign halted      = state == HALT;
   // next state, commit pulse and memory-wait counter
   always_comb begin
      nxt     = state;
      commit  = 1'b0;
      to_err  = 1'b0;
      cnt_nxt = cnt;
      unique case (state)
         IDLE:  nxt = run ? FETCH : IDLE;
         FETCH: nxt = run ? EXEC : FETCH;
         EXEC:
            if (bus.opcode == HALT_OPC) nxt = HALT;
            else if (bus.dec_mem_read || bus.dec_mem_write) begin
               nxt     = MEM;
               cnt_nxt = 8'd0;
            end else begin
               commit = 1'b1;
               nxt    = FETCH;
            end
         MEM:
            if (bus.mem_ack) begin
               commit = 1'b1;
               nxt    = FETCH;
            end else if (cnt == 8'(TIMEOUT - 1)) begin
               nxt    = HALT;
               to_err = 1'b1;
            end else cnt_nxt = cnt + 8'd1;
         HALT:  nxt = HALT;
         default: nxt = IDLE;
      endcase
   end
   // state, IR, PC, flags and registered memory request
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= '0;
         ir          <= '0;
         flags       <= '0;
         cnt         <= '0;
         mem_req     <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state   <= nxt;
         cnt     <= cnt_nxt;
         mem_req <= nxt == MEM;
         if (state == FETCH && run) ir <= bus.instr_in;
         if (commit) pc <= bus.dec_pc_load ? PC_W'(bus.literal) : pc + 1'b1;
         if (commit && bus.dec_flag_we) flags <= {bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v};
         if (to_err) err_timeout <= 1'b1;
      end
   end
`ifdef SEQ_RETIRE_CNT_EN
   // saturating count of committed instructions
   always_ff @(posedge clk) begin
      if (!rst_n) instr_count <= '0;
      else if (commit && instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
   end
`else
   assign instr_count = '0;
`endif
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed checks of fetch/execute timing, jumps, memory wait, timeout and reset
module tb_cpu_sequencer;
   localparam logic [6:0] MOV = 7'h01, CMP = 7'h02, JEQ = 7'h03, LDD = 7'h04, ADDD = 7'h05, JMP = 7'h06;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        halted, err_timeout;
   logic [15:0] instr_count;
   logic [14:0] rom [256];
   int          checks = 0;
   int          errors = 0;
   int          reqs, commits;
   logic [31:0] exp_cnt;
   cpu_sequencer_if #(.PC_W(8), .LIT_W(8)) bus ();
   cpu_sequencer dut (
      .clk(clk), .rst_n(rst_n), .run(run), .bus(bus),
      .halted(halted), .err_timeout(err_timeout), .instr_count(instr_count)
   );
   always #5 clk = ~clk;
   assign bus.instr_in = rom[bus.pc];
   // reference decoder for the small instruction set used here
   always_comb begin
      bus.dec_mem_read  = bus.opcode == LDD || bus.opcode == ADDD;
      bus.dec_mem_write = 1'b0;
      bus.dec_flag_we   = bus.opcode == CMP || bus.opcode == ADDD;
      bus.dec_pc_load   = bus.opcode == JMP || (bus.opcode == JEQ && bus.flag_z);
   end
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic reset_dut();
      rst_n = 1'b0;
      run = 1'b0;
      bus.mem_ack = 1'b0;
      {bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v} = 4'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask
   initial begin
      for (int i = 0; i < 256; i++) rom[i] = '0;
      reset_dut();
      check("rst_pc", 32'(bus.pc), 0);
      check("rst_opcode", 32'(bus.opcode), 0);
      check("rst_flags", 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 0);
      check("rst_req", 32'(bus.mem_req), 0);
      check("rst_commit", 32'(bus.commit), 0);
      check("rst_halted", 32'(halted), 0);
      check("rst_err", 32'(err_timeout), 0);
      check("rst_cnt", 32'(instr_count), 0);
      tick();
      check("idle_hold_pc", 32'(bus.pc), 0);
      check("idle_commit", 32'(bus.commit), 0);
      // MOV A,Lit 5
      rom[0] = {MOV, 8'h05};
      run = 1'b1;
      tick();
      check("mov_fetch_commit", 32'(bus.commit), 0);
      tick();
      check("mov_exec_commit", 32'(bus.commit), 1);
      check("mov_exec_lit", 32'(bus.literal), 32'h05);
      check("mov_exec_req", 32'(bus.mem_req), 0);
      tick();
      check("mov_pc", 32'(bus.pc), 1);
      check("mov_after_commit", 32'(bus.commit), 0);
      // CMP sets Z, JEQ then jumps to 0x20
      reset_dut();
      rom[0] = {CMP, 8'h00};
      rom[1] = {JEQ, 8'h20};
      rom[32] = {ADDD, 8'h10};
      rom[33] = {LDD, 8'h00};
      bus.alu_z = 1'b1;
      run = 1'b1;
      tick();
      tick();
      check("cmp_commit", 32'(bus.commit), 1);
      tick();
      bus.alu_z = 1'b0;
      check("cmp_flag_z", 32'(bus.flag_z), 1);
      check("cmp_pc", 32'(bus.pc), 1);
      tick();
      check("jeq_commit", 32'(bus.commit), 1);
      tick();
      check("jeq_pc", 32'(bus.pc), 32'h20);
      check("jeq_keeps_z", 32'(bus.flag_z), 1);
      // ADD A,(Dir) acked in its third MEM cycle
      bus.alu_n = 1'b1;
      tick();
      check("mem_exec_commit", 32'(bus.commit), 0);
      check("mem_exec_req", 32'(bus.mem_req), 0);
      tick();
      check("mem1_req", 32'(bus.mem_req), 1);
      check("mem1_commit", 32'(bus.commit), 0);
      tick();
      check("mem2_req", 32'(bus.mem_req), 1);
      tick();
      bus.mem_ack = 1'b1;
      #1;
      check("mem3_req", 32'(bus.mem_req), 1);
      check("mem3_commit", 32'(bus.commit), 1);
      tick();
      bus.mem_ack = 1'b0;
      bus.alu_n = 1'b0;
      check("mem_done_req", 32'(bus.mem_req), 0);
      check("mem_done_pc", 32'(bus.pc), 32'h21);
      check("mem_flag_n", 32'(bus.flag_n), 1);
      check("mem_flag_z", 32'(bus.flag_z), 0);
      // LD with no ack times out after 15 wait cycles
      tick();
      reqs = 0;
      commits = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         reqs += 32'(bus.mem_req);
         commits += 32'(bus.commit);
      end
      check("to_req_cycles", 32'(reqs), 15);
      check("to_commits", 32'(commits), 0);
      check("to_not_yet", 32'(halted), 0);
      tick();
      check("to_halted", 32'(halted), 1);
      check("to_err", 32'(err_timeout), 1);
      check("to_req_drop", 32'(bus.mem_req), 0);
      check("to_pc", 32'(bus.pc), 32'h21);
      bus.mem_ack = 1'b1;
      #1;
      check("halt_ack_commit", 32'(bus.commit), 0);
      tick();
      bus.mem_ack = 1'b0;
      check("halt_stays", 32'(halted), 1);
      check("halt_pc", 32'(bus.pc), 32'h21);
      reset_dut();
      check("rst_clr_halt", 32'(halted), 0);
      check("rst_clr_err", 32'(err_timeout), 0);
      check("rst_clr_pc", 32'(bus.pc), 0);
      // ack arriving on the 15th wait cycle wins over the timeout
      rom[0] = {LDD, 8'h00};
      run = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 14; i++) tick();
      tick();
      bus.mem_ack = 1'b1;
      #1;
      check("edge_ack_commit", 32'(bus.commit), 1);
      tick();
      bus.mem_ack = 1'b0;
      check("edge_ack_halted", 32'(halted), 0);
      check("edge_ack_err", 32'(err_timeout), 0);
      check("edge_ack_pc", 32'(bus.pc), 1);
      // PC wrap at 0xFF, then pause in FETCH
      reset_dut();
      rom[0] = {JMP, 8'hFF};
      rom[255] = {MOV, 8'h00};
      run = 1'b1;
      tick();
      tick();
      tick();
      check("jmp_pc_ff", 32'(bus.pc), 32'hFF);
      tick();
      tick();
      check("wrap_pc", 32'(bus.pc), 0);
      run = 1'b0;
      tick();
      tick();
      tick();
      check("pause_pc", 32'(bus.pc), 0);
      check("pause_ir", 32'(bus.opcode), 32'(MOV));
      check("pause_commit", 32'(bus.commit), 0);
      run = 1'b1;
      tick();
      check("resume_ir", 32'(bus.opcode), 32'(JMP));
      check("resume_commit", 32'(bus.commit), 1);
      // three retirements, then reset in the middle of a memory wait
      reset_dut();
      rom[0] = {MOV, 8'h00};
      rom[1] = {MOV, 8'h00};
      rom[2] = {MOV, 8'h00};
      rom[3] = {LDD, 8'h00};
      run = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      check("three_pc", 32'(bus.pc), 3);
`ifdef SEQ_RETIRE_CNT_EN
      exp_cnt = 3;
`else
      exp_cnt = 0;
`endif
      check("retire_cnt", 32'(instr_count), exp_cnt);
      tick();
      tick();
      check("mid_mem_req", 32'(bus.mem_req), 1);
      rst_n = 1'b0;
      tick();
      check("midrst_req", 32'(bus.mem_req), 0);
      check("midrst_pc", 32'(bus.pc), 0);
      check("midrst_err", 32'(err_timeout), 0);
      check("midrst_cnt", 32'(instr_count), 0);
      rst_n = 1'b1;
      run = 1'b0;
      tick();
      tick();
      check("midrst_idle_pc", 32'(bus.pc), 0);
      check("midrst_idle_req", 32'(bus.mem_req), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle fetch/execute sequencer for the ARC CPU. It owns the PC, the instruction register and the registered ALU flags, and drives the existing combinational decoder from the latched opcode. It issues a single-pulse commit that qualifies all register loads and PC updates. Memory-class instructions stall in a req/ack handshake with data memory; a watchdog timeout halts the core on a missing ack.

Parameters:
PC_W, 8, program counter width (ROM depth 2**PC_W)
LIT_W, 8, literal field width; instruction = {opcode[6:0], literal[LIT_W-1:0]}
HALT_OPC, 7'b1111111, opcode that enters HALT
TIMEOUT, 15, maximum cycles mem_req may wait for mem_ack (1..255)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
run  in  1  1 = execute; 0 = pause at FETCH boundary
instr_in  in  7+LIT_W  ROM data for address pc (combinational ROM)
pc  out  PC_W  program counter / ROM address
opcode  out  7  IR opcode field to decoder
literal  out  LIT_W  IR literal field to datapath
dec_mem_read  in  1  decoder: instruction reads data memory
dec_mem_write  in  1  decoder: instruction writes data memory
dec_pc_load  in  1  decoder: take jump (already condition-qualified)
dec_flag_we  in  1  decoder: instruction updates flags (ALU ops, CMP)
alu_z, alu_n, alu_c, alu_v  in  1 each  live ALU flags
flag_z, flag_n, flag_c, flag_v  out  1 each  registered flags to decoder
mem_req  out  1  data memory access request
mem_ack  in  1  data memory done (read data valid / write accepted)
commit  out  1  one-cycle pulse; qualifies loadA/loadB/mem_write
halted  out  1  core in HALT
err_timeout  out  1  sticky; HALT caused by mem timeout
instr_count  out  16  retired-instruction count (optional feature)

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, pc=0, IR=0, flags=0, mem_req=0, commit=0, halted=0, err_timeout=0, timeout counter=0, instr_count=0. Reset overrides everything, including mid-MEM and HALT.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: run=0 -> stay, IR unchanged. run=1 -> IR<=instr_in -> EXEC.
- EXEC (opcode and literal stable from IR):
  - opcode==HALT_OPC: -> HALT, no commit.
  - dec_mem_read|dec_mem_write: -> MEM, counter<=0. mem_req is a registered output, high from the first MEM cycle.
  - Otherwise: commit=1 this cycle; PC update; flags <= alu_* if dec_flag_we; -> FETCH.
- MEM: mem_req=1.
  - mem_ack=1: commit=1 this cycle, mem_req drops next cycle, PC update, flags update if dec_flag_we (ADD A,(Dir)) -> FETCH.
  - No ack: counter+1; when counter reaches TIMEOUT with no ack: -> HALT, err_timeout<=1, no commit.
  - If ack arrives in the same cycle the counter reaches TIMEOUT, ack wins.
- HALT: halted=1, mem_req=0, commit=0; exit only by reset.
- PC update on commit: dec_pc_load ? literal[PC_W-1:0] (zero-extended if LIT_W<PC_W) : pc+1 mod 2**PC_W; 2**PC_W-1 wraps to 0.
- Flags are registered, so no combinational loop exists through the decoder. JEQ uses Z from the last committed flag-writing instruction.
- Latency: non-memory instruction = 2 cycles (FETCH, EXEC); memory instruction = 2 + k cycles, k = cycles until ack (minimum 1).
- commit asserted at most one cycle per instruction; never in IDLE, FETCH or HALT.
- mem_ack outside MEM is ignored.

Optional Feature:
SEQ_RETIRE_CNT_EN: when defined, instr_count increments on every commit and saturates at 16'hFFFF. When undefined, instr_count is tied to 0 and no counter logic exists.

Test Plan:
- Reset, run=1, ROM[0]=MOV A,Lit 5 -> commit pulses exactly in cycle 2 after run, pc 0->1, mem_req never high.
- ROM[0]=CMP A,Lit with alu_z=1, ROM[1]=JEQ 8'h20 (dec_pc_load=flag_z) -> flag_z=1 after first commit, pc=0x20 after second commit.
- MOV A,(Dir) with mem_ack after 3 cycles -> mem_req high exactly 3 cycles, single commit on ack cycle, instruction takes 5 cycles.
- Memory op, mem_ack held 0, TIMEOUT=15 -> HALT after 15 wait cycles, halted=1, err_timeout=1, no commit, pc unchanged.
- pc=0xFF non-jump commit -> pc=0x00. Then run=0 in FETCH -> pc and IR frozen; run=1 resumes.
- rst_n=0 during MEM with mem_req=1 -> next cycle mem_req=0, pc=0, state IDLE, err_timeout=0. With SEQ_RETIRE_CNT_EN, instr_count=0 after reset and 3 after three retired instructions.
